// File: rtl/mod_addsub_bist_if.sv
// Operand/result bundle between the BIST engine and the modular add/sub datapath.
// The master side drives the operation and operands and receives the residue.
interface mod_addsub_bist_if;
    logic       s;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;

    modport master (output s, output x, output y, input z);
    modport slave  (input s, input x, input y, output z);
endinterface

// File: rtl/mod_addsub_bist.sv
// Built-in self-test sweep for the 4-bit modular adder/subtractor: drives every legal
// (s, x, y), checks z against an independent residue. Optional: MOD_ADDSUB_BIST_FAIL_CAPTURE_EN.
module mod_addsub_bist #(
    parameter logic [3:0] M      = 4'b1111,
    parameter int         SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    mod_addsub_bist_if.master   main_if,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [8:0]          total_count,
    output logic [8:0]          pass_count
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
    ,
    output logic                fail_valid,
    output logic                fail_s,
    output logic [3:0]          fail_x,
    output logic [3:0]          fail_y,
    output logic [3:0]          fail_z
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    localparam logic [4:0] M5         = {1'b0, M};
    localparam logic [3:0] M_LAST     = M - 4'd1;
    localparam logic [3:0] SETTLE_LD  = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       s_q;
    logic [3:0] x_q, y_q;
    logic       begin_sweep, do_check;
    logic       last_vec, match;

    // Residue computed with a 5-bit intermediate so x + y and x - y + M never wrap.
    function automatic logic [3:0] mod_result(input logic sub, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b};
            if (t >= M5)
                t = t - M5;
        end else if (a >= b) begin
            t = {1'b0, a} - {1'b0, b};
        end else begin
            t = {1'b0, a} + M5 - {1'b0, b};
        end
        return t[3:0];
    endfunction

    assign last_vec = s_q && (x_q == M_LAST) && (y_q == M_LAST);
    assign match    = (main_if.z == mod_result(s_q, x_q, y_q));

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        begin_sweep = 1'b0;
        do_check    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    begin_sweep = 1'b1;
                    state_nxt   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0)
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                do_check  = 1'b1;
                state_nxt = last_vec ? ST_DONE : ST_SETTLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Vector generator, settle timer and scoreboard counters
    always_ff @(posedge clk) begin
        if (rst || begin_sweep) begin
            s_q         <= 1'b0;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            total_count <= 9'd0;
            pass_count  <= 9'd0;
            settle_cnt  <= rst ? 4'd0 : SETTLE_LD;
        end else if (state == ST_SETTLE) begin
            if (settle_cnt != 4'd0)
                settle_cnt <= settle_cnt - 4'd1;
        end else if (do_check) begin
            total_count <= total_count + 9'd1;
            if (match)
                pass_count <= pass_count + 9'd1;
            if (!last_vec) begin
                settle_cnt <= SETTLE_LD;
                if (y_q == M_LAST) begin
                    y_q <= 4'd0;
                    if (x_q == M_LAST) begin
                        x_q <= 4'd0;
                        s_q <= 1'b1;
                    end else begin
                        x_q <= x_q + 4'd1;
                    end
                end else begin
                    y_q <= y_q + 4'd1;
                end
            end
        end
    end

`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
    // Only the first mismatch of a sweep is kept.
    always_ff @(posedge clk) begin
        if (rst || begin_sweep) begin
            fail_valid <= 1'b0;
            fail_s     <= 1'b0;
            fail_x     <= 4'd0;
            fail_y     <= 4'd0;
            fail_z     <= 4'd0;
        end else if (do_check && !match && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_s     <= s_q;
            fail_x     <= x_q;
            fail_y     <= y_q;
            fail_z     <= main_if.z;
        end
    end
`endif

    assign main_if.s = s_q;
    assign main_if.x = x_q;
    assign main_if.y = y_q;
    assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done      = (state == ST_DONE);
    assign pass      = done && (pass_count == total_count);

endmodule

// File: tb/tb_mod_addsub_bist.sv
// Directed bench: two BIST instances (M=15/SETTLE=1, M=9/SETTLE=2) against a behavioural
// datapath model with selectable corruption.
module tb_mod_addsub_bist;
    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [8:0] total_a, passc_a, total_b, passc_b;
    int fault_mode;
    int n_vec = 0;
    int n_err = 0;
    int busy_gap = 0;
    int max_xa = 0, max_ya = 0, max_xb = 0, max_yb = 0, bad_xy_b = 0;
    int cyc;

`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
    logic fv_a, fs_a, fv_b, fs_b;
    logic [3:0] fx_a, fy_a, fz_a, fx_b, fy_b, fz_b;
`endif

    mod_addsub_bist_if ifa();
    mod_addsub_bist_if ifb();

    always #5 clk = ~clk;

    mod_addsub_bist #(.M(4'd15), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .main_if(ifa.master),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .total_count(total_a), .pass_count(passc_a)
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv_a), .fail_s(fs_a), .fail_x(fx_a), .fail_y(fy_a), .fail_z(fz_a)
`endif
    );

    mod_addsub_bist #(.M(4'd9), .SETTLE(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .main_if(ifb.master),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .total_count(total_b), .pass_count(passc_b)
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv_b), .fail_s(fs_b), .fail_x(fx_b), .fail_y(fy_b), .fail_z(fz_b)
`endif
    );

    function automatic logic [3:0] main_model(input logic s, input logic [3:0] x, input logic [3:0] y, input int m);
        int r;
        if (!s)
            r = (int'(x) + int'(y)) % m;
        else
            r = (int'(x) - int'(y) + m) % m;
        return r[3:0];
    endfunction

    always_comb begin
        ifa.z = main_model(ifa.s, ifa.x, ifa.y, 15);
        if (fault_mode == 1)
            ifa.z = ifa.z & 4'b1110;
        else if (fault_mode == 2 && ifa.s && ifa.x == 4'd0 && ifa.y == 4'd1)
            ifa.z = 4'd0;
    end

    always_comb ifb.z = main_model(ifb.s, ifb.x, ifb.y, 9);

    always @(posedge clk) begin
        if (busy_a) begin
            if (int'(ifa.x) > max_xa) max_xa <= int'(ifa.x);
            if (int'(ifa.y) > max_ya) max_ya <= int'(ifa.y);
        end
        if (busy_b) begin
            if (int'(ifb.x) > max_xb) max_xb <= int'(ifb.x);
            if (int'(ifb.y) > max_yb) max_yb <= int'(ifb.y);
            if (ifb.x > 4'd8 || ifb.y > 4'd8) bad_xy_b <= bad_xy_b + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a sweep on instance A; cyc counts edges after the start edge until done.
    task automatic run_a(input int poke_at, input int rst_at, output int cycles);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        cycles = 0;
        while (!done_a && cycles < 2000) begin
            if (cycles == rst_at) begin
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            cycles++;
            start_a = (cycles == poke_at);
            if (!done_a && !busy_a) busy_gap++;
        end
        start_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; fault_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        check("reset_pass", pass_a, 0);
        check("reset_total", total_a, 0);
        check("reset_passc", passc_a, 0);
        check("reset_sxy", {ifa.s, ifa.x, ifa.y}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_stays", busy_a, 0);

        // Clean sweep, M=15, SETTLE=1
        run_a(-1, -1, cyc);
        check("a_cycles", cyc, 900);
        check("a_total", total_a, 450);
        check("a_passc", passc_a, 450);
        check("a_pass", pass_a, 1);
        check("a_busy_at_done", busy_a, 0);
        check("a_busy_gap", busy_gap, 0);
        check("a_last_vec", {ifa.s, ifa.x, ifa.y}, {1'b1, 4'd14, 4'd14});
        check("a_max_x", max_xa, 14);
        check("a_max_y", max_ya, 14);
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        check("a_fail_valid_clean", fv_a, 0);
`endif
        repeat (5) @(posedge clk);
        #1;
        check("a_done_hold", done_a, 1);
        check("a_total_hold", total_a, 450);

        // Second start while busy must be ignored
        run_a(100, -1, cyc);
        check("poke_cycles", cyc, 900);
        check("poke_total", total_a, 450);
        check("poke_passc", passc_a, 450);

        // z0 stuck at 0
        fault_mode = 1;
        run_a(-1, -1, cyc);
        check("z0_total", total_a, 450);
        check("z0_passc", passc_a, 240);
        check("z0_pass", pass_a, 0);
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        check("z0_fail_valid", fv_a, 1);
        check("z0_fail_sxyz", {fs_a, fx_a, fy_a, fz_a}, {1'b0, 4'd0, 4'd1, 4'd0});
`endif

        // Single corrupted vector s=1, x=0, y=1
        fault_mode = 2;
        run_a(-1, -1, cyc);
        check("one_total", total_a, 450);
        check("one_passc", passc_a, 449);
        check("one_pass", pass_a, 0);
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        check("one_fail_valid", fv_a, 1);
        check("one_fail_sxyz", {fs_a, fx_a, fy_a, fz_a}, {1'b1, 4'd0, 4'd1, 4'd0});
`endif

        // Reset mid-sweep at cycle 300
        fault_mode = 0;
        run_a(-1, 300, cyc);
        check("rst_reached", cyc, 300);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_total", total_a, 0);
        check("rst_passc", passc_a, 0);
        check("rst_sxy", {ifa.s, ifa.x, ifa.y}, 0);
        busy_gap = 0;
        run_a(-1, -1, cyc);
        check("post_rst_cycles", cyc, 900);
        check("post_rst_total", total_a, 450);
        check("post_rst_passc", passc_a, 450);
        check("post_rst_pass", pass_a, 1);
        check("post_rst_busy_gap", busy_gap, 0);

        // Instance B: M=9, SETTLE=2
        check("b_idle_done", done_b, 0);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b_cycles", cyc, 486);
        check("b_total", total_b, 162);
        check("b_passc", passc_b, 162);
        check("b_pass", pass_b, 1);
        check("b_busy_at_done", busy_b, 0);
        check("b_xy_range", bad_xy_b, 0);
        check("b_max_x", max_xb, 8);
        check("b_max_y", max_yb, 8);
        check("b_last_vec", {ifb.s, ifb.x, ifb.y}, {1'b1, 4'd8, 4'd8});
`ifdef MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
        check("b_fail_valid", fv_b, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mod_addsub_bist.md
Name: mod_addsub_bist

Overview:
- Sequential built-in self-test engine for the 4-bit modular adder/subtractor (`MAIN`). It sits on the opposite side of that block's interface: it drives `s`/x/y and consumes z.
- Sweeps every legal (s, x, y) combination for modulus M and computes the expected residue independently.
- Compares each expected value against the returned z and reports total and passing counts.
- Used for on-silicon/FPGA checking of the `MAIN` datapath.

Parameters:
- M, 4'b1111, modulus under test; legal range 4'b1001..4'b1111; must equal the `MAIN` instance's m.
- SETTLE, 1, clock cycles a vector is held before z is sampled; range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a sweep when idle or done
- s  out  1  operation to `MAIN`: 0 = add, 1 = subtract
- x  out  4  operand x to `MAIN`; x[3:0] maps to x3..x0
- y  out  4  operand y to `MAIN`; y[3:0] maps to y3..y0
- z  in  4  result from `MAIN`; z[3:0] maps to z3..z0
- busy  out  1  high while a sweep is running
- done  out  1  high from end of sweep until next start or rst
- pass  out  1  valid when done; 1 iff pass_count == total_count
- total_count  out  9  vectors checked (max 2*15*15 = 450)
- pass_count  out  9  vectors whose z matched expected

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - state IDLE; s, x, y = 0.
  - busy, done, pass = 0.
  - Both counters = 0.
  - rst has priority over everything, including mid-sweep; the sweep is abandoned with no partial result held.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1:
  - Clear counters; s = 0, x = 0, y = 0.
  - Load settle counter with SETTLE-1; go to SETTLE.
  - busy = 1, done = 0.
- SETTLE: vector held stable; decrement settle counter; at 0 go to CHECK.
- CHECK:
  - Sample z; total_count += 1; pass_count += 1 if z == expected.
  - If the vector is the last one, go to DONE.
  - Otherwise advance the vector, reload the settle counter, and go to SETTLE.
- Iteration order:
  - y inner: 0..M-1; on wrap, y returns to 0 and x increments.
  - x middle: 0..M-1; on wrap, x returns to 0 and s flips 0->1.
  - s outer.
  - Last vector: s = 1, x = M-1, y = M-1.
  - x and y never take values >= M.
- Expected value, computed with 5-bit intermediate:
  - s = 0: t = x + y; expected = t - M if t >= M, else t.
  - s = 1: expected = x - y if x >= y, else x - y + M.
  - Result is always in 0..M-1.
- Timing:
  - Each vector occupies SETTLE + 1 cycles.
  - start sampled at edge k -> done rises at edge k + 2*M*M*(SETTLE+1).
  - busy falls on the same edge.
- DONE: holds done = 1, pass, and counters stable; s/x/y hold the last vector.
- start while busy: ignored.
- start with rst: rst wins.
- Counters cannot overflow (max 450 < 512).

Optional Feature:
- Macro: MOD_ADDSUB_BIST_FAIL_CAPTURE_EN
- Defined: adds outputs fail_valid (1), fail_s (1), fail_x (4), fail_y (4), fail_z (4).
  - Captured in the first CHECK cycle with a mismatch; later mismatches do not overwrite the capture.
  - All cleared to 0 by rst and by an accepted start.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- M=15, SETTLE=1, correct `MAIN` model on z, start pulse -> busy for 900 cycles, then done=1, total_count=450, pass_count=450, pass=1.
- M=9, SETTLE=2, correct model -> done after 486 cycles, total_count=162, pass_count=162, pass=1; x and y never exceed 8.
- M=15, z0 forced to 0 -> total_count=450, pass_count=240, pass=0; with the feature enabled, fail_s=0, fail_x=0, fail_y=1, fail_z=0.
- M=15, model corrupted only at s=1, x=0, y=1 (returns 0 instead of 14) -> pass_count=449, pass=0; fail_x=0, fail_y=1, fail_z=0.
- rst asserted at cycle 300 of a sweep -> next edge: busy=0, done=0, counters=0, s/x/y=0. A new start then completes normally with 450/450.
- start pulsed again at cycle 100 while busy -> no restart; done still at cycle 900 with total_count=450.
